// File: rtl/mux_nx1_bus_reg.sv
// mux_nx1_bus_reg: parametrised N-to-1 bus multiplexer with a latched
// channel register and a registered output. Supports direct channel loads
// with out-of-range rejection, and a round-robin scan mode that advances
// one channel per step command. All outputs come straight from flops.
module mux_nx1_bus_reg #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   D,
  input  logic [SELW-1:0]      S,
  input  logic                 load,
  input  logic                 mode,
  input  logic                 step,
  output logic [WIDTH-1:0]     Q,
  output logic [SELW-1:0]      sel_q,
  output logic                 valid,
  output logic                 sel_err,
  output logic                 wrap
);

  // N widened by one bit so the range compare never truncates S or N.
  localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

  logic [SELW-1:0]  sel_q_r;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             sel_err_r;
  logic             wrap_r;

  logic             s_in_range_s;
  logic [SELW-1:0]  sel_nxt_s;
  logic             sel_err_nxt_s;
  logic             wrap_nxt_s;
  logic [WIDTH-1:0] sel_data_s;

  // Next-sequential channel index in scan order, wrapping N-1 back to 0.
  function automatic logic [SELW-1:0] scan_next(input logic [SELW-1:0] cur);
    logic [SELW-1:0] nxt;
    if (cur == LAST_SEL) begin
      nxt = {SELW{1'b0}};
    end else begin
      nxt = cur + SELW'(1);
    end
    return nxt;
  endfunction

  assign s_in_range_s = ({1'b0, S} < N_EXT);

  // Channel register next state: load beats step, step only counts in scan mode.
  always_comb begin
    sel_nxt_s     = sel_q_r;
    sel_err_nxt_s = 1'b0;
    wrap_nxt_s    = 1'b0;
    if (load) begin
      if (s_in_range_s) begin
        sel_nxt_s = S;
      end else begin
        sel_err_nxt_s = 1'b1;
      end
    end else if (mode && step) begin
      sel_nxt_s  = scan_next(sel_q_r);
      wrap_nxt_s = (sel_q_r == LAST_SEL);
    end else begin
      sel_nxt_s = sel_q_r;
    end
  end

  // AND-OR selection of the channel addressed by the current (pre-edge) sel_q.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_data_s = sel_data_s |
                   (D[i*WIDTH +: WIDTH] & {WIDTH{sel_q_r == SELW'(i)}});
    end
  end

  // State and output registers; reset clears the channel and flags at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q_r   <= {SELW{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      sel_err_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      sel_q_r   <= sel_nxt_s;
      q_r       <= sel_data_s;
      valid_r   <= 1'b1;
      sel_err_r <= sel_err_nxt_s;
      wrap_r    <= wrap_nxt_s;
    end
  end

  assign Q       = q_r;
  assign sel_q   = sel_q_r;
  assign valid   = valid_r;
  assign sel_err = sel_err_r;
  assign wrap    = wrap_r;

endmodule
